// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-word constants, program loader state encoding and defaults.
// LOADER_CHECKSUM_EN adds the loader's CHECK state.
package cpu_pkg;

  localparam int unsigned RAM_BYTES_DEFAULT = 16;

  localparam logic [7:0] CW_NOP   = 8'h00;
  localparam logic [7:0] CW_FETCH = 8'h01;
  localparam logic [7:0] CW_EXEC  = 8'h02;
  localparam logic [7:0] CW_HALT  = 8'h80;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_ACCEPT = 3'd1,
    LD_WRITE  = 3'd2,
    LD_CHECK  = 3'd3,
    LD_FINISH = 3'd4
  } ld_state_e;
`else
  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_ACCEPT = 3'd1,
    LD_WRITE  = 3'd2,
    LD_FINISH = 3'd4
  } ld_state_e;
`endif

endpackage

// File: rtl/program_loader_if.sv
// Host byte stream, RAM write port and CPU hold/status signals of the program loader.
interface program_loader_if #(
  parameter int unsigned ADDR_W = $clog2(cpu_pkg::RAM_BYTES_DEFAULT)
);
  logic              start;
  logic [7:0]        data_in;
  logic              data_valid;
  logic              data_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              ram_we;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    output start, data_in, data_valid,
    input  data_ready, ram_addr, ram_wdata, ram_we, cpu_hold, done, error
  );

  modport slave (
    input  start, data_in, data_valid,
    output data_ready, ram_addr, ram_wdata, ram_we, cpu_hold, done, error
  );
endinterface

// File: rtl/program_loader.sv
// Loads RAM_BYTES program bytes from the host into RAM while holding the CPU.
// Define LOADER_CHECKSUM_EN to accept and verify a trailing checksum byte.
module program_loader
  import cpu_pkg::*;
#(
  parameter int unsigned RAM_BYTES = RAM_BYTES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  program_loader_if.slave  bus
);

  localparam int unsigned ADDR_W = (RAM_BYTES > 1) ? $clog2(RAM_BYTES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        sum_chk;
  logic              err_q, err_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LD_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
    sum_chk = sum_q + bus.data_in;
`endif
    unique case (state_q)
      LD_IDLE: begin
        if (bus.start) begin
          addr_d  = '0;
          state_d = LD_ACCEPT;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      LD_ACCEPT: begin
        if (bus.data_valid) begin
          wdata_d = bus.data_in;
          state_d = LD_WRITE;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_q + bus.data_in;
`endif
        end
      end
      LD_WRITE: begin
        // Address saturates at the last word so a load never wraps.
        if (addr_q != LAST_ADDR) begin
          addr_d  = addr_q + 1'b1;
          state_d = LD_ACCEPT;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_d = LD_CHECK;
`else
          state_d = LD_FINISH;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      LD_CHECK: begin
        if (bus.data_valid) begin
          err_d   = (sum_chk != 8'h00);
          state_d = LD_FINISH;
        end
      end
`endif
      LD_FINISH: state_d = LD_IDLE;
      default:   state_d = LD_IDLE;
    endcase
  end

  // All handshake/strobe outputs decode the registered state only.
`ifdef LOADER_CHECKSUM_EN
  assign bus.data_ready = (state_q == LD_ACCEPT) || (state_q == LD_CHECK);
  assign bus.error      = err_q;
`else
  assign bus.data_ready = (state_q == LD_ACCEPT);
  assign bus.error      = 1'b0;
`endif
  assign bus.ram_we    = (state_q == LD_WRITE);
  assign bus.done      = (state_q == LD_FINISH);
  assign bus.cpu_hold  = (state_q != LD_IDLE);
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;

endmodule
